// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three client ports, the SDRAM-controller side and the grant
// indicator shared between mem_port_arbiter and its surroundings.
interface mem_port_arbiter_if;
  logic [23:0] p1_address, p2_address, p3_address;
  logic        p1_req,     p2_req,     p3_req;
  logic        p1_wren,    p2_wren,    p3_wren;
  logic [15:0] p1_to_mem,  p2_to_mem,  p3_to_mem;
  logic        p1_ready,   p2_ready,   p3_ready;
  logic [1:0]  p1_offset,  p2_offset,  p3_offset;

  logic [23:0] mem_address;
  logic        mem_req;
  logic        mem_wren;
  logic [15:0] mem_to_mem;
  logic        mem_ready;
  logic [1:0]  mem_offset;

  logic [1:0]  grant;

  // Arbiter side
  modport master (
    input  p1_address, p2_address, p3_address,
    input  p1_req, p2_req, p3_req,
    input  p1_wren, p2_wren, p3_wren,
    input  p1_to_mem, p2_to_mem, p3_to_mem,
    output p1_ready, p2_ready, p3_ready,
    output p1_offset, p2_offset, p3_offset,
    output mem_address, mem_req, mem_wren, mem_to_mem,
    input  mem_ready, mem_offset,
    output grant
  );

  // Clients plus memory controller side
  modport slave (
    output p1_address, p2_address, p3_address,
    output p1_req, p2_req, p3_req,
    output p1_wren, p2_wren, p3_wren,
    output p1_to_mem, p2_to_mem, p3_to_mem,
    input  p1_ready, p2_ready, p3_ready,
    input  p1_offset, p2_offset, p3_offset,
    input  mem_address, mem_req, mem_wren, mem_to_mem,
    output mem_ready, mem_offset,
    input  grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (p3 > p2 > p1) burst arbiter for one SDRAM channel, with a
// streak limit that stops back-to-back display fetches starving the caches.
module mem_port_arbiter #(
  parameter int BURST_LEN     = 4,
  parameter int P3_MAX_CONSEC = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.master bus
);

  localparam int SW = $clog2(P3_MAX_CONSEC + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    grant_q, grant_nxt;
  logic          mem_req_q, mem_req_nxt;
  logic          mem_wren_q, mem_wren_nxt;
  logic [SW-1:0] p3_streak, p3_streak_nxt;

  logic          p3_masked;
  logic [1:0]    winner;
  logic          winner_wren;
  logic          last_strobe;

  // p3 loses its top priority once it has used up its streak and a cache waits
  always_comb begin
    winner      = 2'd0;
    winner_wren = 1'b0;
    p3_masked   = (p3_streak == SW'(P3_MAX_CONSEC)) && (bus.p1_req || bus.p2_req);
    if (bus.p3_req && !p3_masked) begin
      winner      = 2'd3;
      winner_wren = bus.p3_wren;
    end else if (bus.p2_req) begin
      winner      = 2'd2;
      winner_wren = bus.p2_wren;
    end else if (bus.p1_req) begin
      winner      = 2'd1;
      winner_wren = bus.p1_wren;
    end
  end

  assign last_strobe = bus.mem_ready && (bus.mem_offset == 2'(BURST_LEN - 1));

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_q;
    mem_req_nxt   = mem_req_q;
    mem_wren_nxt  = mem_wren_q;
    p3_streak_nxt = p3_streak;
    case (state)
      IDLE: begin
        if (winner != 2'd0) begin
          state_nxt    = BUSY;
          grant_nxt    = winner;
          mem_req_nxt  = 1'b1;
          mem_wren_nxt = winner_wren;
          if (winner == 2'd3) begin
            if (p3_streak != SW'(P3_MAX_CONSEC))
              p3_streak_nxt = p3_streak + SW'(1);
          end else begin
            p3_streak_nxt = '0;
          end
        end
      end
      BUSY: begin
        if (last_strobe) begin
          state_nxt    = DONE;
          grant_nxt    = 2'd0;
          mem_req_nxt  = 1'b0;
          mem_wren_nxt = 1'b0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt    = IDLE;
        grant_nxt    = 2'd0;
        mem_req_nxt  = 1'b0;
        mem_wren_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= 2'd0;
      mem_req_q  <= 1'b0;
      mem_wren_q <= 1'b0;
      p3_streak  <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      mem_req_q  <= mem_req_nxt;
      mem_wren_q <= mem_wren_nxt;
      p3_streak  <= p3_streak_nxt;
    end
  end

  // grant is only nonzero in BUSY, so strobes outside a burst never reach a client
  always_comb begin
    bus.mem_address = '0;
    bus.mem_to_mem  = '0;
    bus.p1_ready    = 1'b0;
    bus.p2_ready    = 1'b0;
    bus.p3_ready    = 1'b0;
    bus.p1_offset   = 2'd0;
    bus.p2_offset   = 2'd0;
    bus.p3_offset   = 2'd0;
    case (grant_q)
      2'd1: begin
        bus.mem_address = bus.p1_address;
        bus.mem_to_mem  = bus.p1_to_mem;
        bus.p1_ready    = bus.mem_ready;
        bus.p1_offset   = bus.mem_offset;
      end
      2'd2: begin
        bus.mem_address = bus.p2_address;
        bus.mem_to_mem  = bus.p2_to_mem;
        bus.p2_ready    = bus.mem_ready;
        bus.p2_offset   = bus.mem_offset;
      end
      2'd3: begin
        bus.mem_address = bus.p3_address;
        bus.mem_to_mem  = bus.p3_to_mem;
        bus.p3_ready    = bus.mem_ready;
        bus.p3_offset   = bus.mem_offset;
      end
      default: ;
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_wren = mem_wren_q;

endmodule
